multi_digit_counter: RTL and testbench
======================================

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 The block SHALL have one clock, CLOCK_50; reset RESET_N is synchronous and active-low.
REQ-002 Parameter CLK_HZ, default 50000000: input clock frequency.
REQ-003 Parameter TICK_HZ, default 1: count rate; the divider DIV = CLK_HZ/TICK_HZ SHALL be at least 2.
REQ-004 Parameter DIGITS, default 4: number of 4-bit digits, range 1..8.
REQ-005 Parameter RADIX, default 16: per-digit radix, either 10 or 16.
REQ-006 Parameter LED_W, default 8: walker LED width, at least 2.
REQ-007 Ports SHALL be as follows:
- CLOCK_50 in 1: clock.
- RESET_N in 1: synchronous active-low reset.
- iRUN in 1: 1 = count, 0 = pause; prescaler and count hold.
- iDIR in 1: 1 = up, 0 = down; sampled on the tick cycle.
- iCLR in 1: synchronous clear.
- iLOAD in 1: load strobe.
- iLOAD_VAL in 4*DIGITS: load value, digit 0 in bits [3:0].
- oCOUNT out 4*DIGITS: current count.
- oSEG out 7*DIGITS: active-low segments, bit 0 = segment a, digit d in bits [7d+6:7d].
- oLED out LED_W: one-hot walker.
- oTICK out 1: one-cycle tick pulse.
- oWRAP out 1: one-cycle wrap pulse.

Function
REQ-008 The prescaler SHALL count 0..DIV-1 while iRUN=1 and hold its value while iRUN=0.
REQ-009 On the edge where the prescaler equals DIV-1 with iRUN=1, the block SHALL, on that same edge: reset the prescaler to 0, set oTICK=1 for exactly one cycle, and update oCOUNT.
REQ-010 Up-count (iDIR=1) SHALL increment digit 0; any digit at RADIX-1 SHALL become 0 and carry into the next digit.
REQ-011 Down-count (iDIR=0) SHALL decrement digit 0; any digit at 0 SHALL become RADIX-1 and borrow from the next digit.
REQ-012 Wrap-around SHALL be all digits RADIX-1 -> all 0 when counting up and all 0 -> all RADIX-1 when counting down; oWRAP SHALL be 1 during the same cycle as the corresponding oTICK.
REQ-013 oLED SHALL rotate left by one position on each up tick and right by one on each down tick, wrapping at both ends, and SHALL remain one-hot at all times.
REQ-014 iLOAD=1 SHALL copy iLOAD_VAL to oCOUNT on the next edge, reset the prescaler to 0, and leave oLED unchanged; with RADIX=10, any load digit above 9 SHALL be clamped to 9.
REQ-015 iCLR=1 SHALL set oCOUNT=0, set the prescaler to 0, and set oLED to 1 on the next edge.
REQ-016 Priority SHALL be RESET_N, then iCLR, then iLOAD, then tick; a tick coinciding with iCLR or iLOAD SHALL be discarded, with no oTICK and no oWRAP.
REQ-017 oSEG SHALL be registered and reflect oCOUNT with one cycle of latency, using a hex glyph set covering 0-F.
REQ-018 oTICK and oWRAP SHALL be 0 in every cycle other than those defined above.

Reset
REQ-019 With RESET_N=0 at an edge, the block SHALL set prescaler=0, oCOUNT=0, oLED=1, oTICK=0, oWRAP=0, and oSEG to the glyph for "0" on every digit (7'b1000000).
REQ-020 A reset asserted mid-count SHALL discard any pending tick; counting SHALL resume from 0 with a full DIV period after release.

Configuration
REQ-021 When macro BLANK_LEADING_ZERO_EN is defined, every zero digit above the most significant nonzero digit SHALL drive oSEG=7'b1111111 (blank), and digit 0 SHALL always display.
REQ-022 When BLANK_LEADING_ZERO_EN is undefined, all digits SHALL always display, zeros included; oCOUNT SHALL be unaffected in both builds.

Verification
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=2, LED_W=8.
REQ-023 Scenario, up-count: RADIX=16, iRUN=1, iDIR=1, 10 cycles after reset -> oTICK pulses on cycle 10, oCOUNT=8'h01, oLED=8'h02.
REQ-024 Scenario, up-wrap: RADIX=10, load 8'h99, iDIR=1, one tick -> oCOUNT=8'h00, oWRAP=1 with oTICK, oLED rotated left.
REQ-025 Scenario, down-borrow: RADIX=10, load 8'h10, iDIR=0, one tick -> oCOUNT=8'h09, oWRAP=0; a further 9 ticks -> 8'h00; one more -> 8'h99 with oWRAP=1.
REQ-026 Scenario, pause and collision: iRUN=0 for 25 cycles -> no oTICK and prescaler frozen; iCLR on the tick cycle -> oCOUNT=0, oLED=1, oTICK=0.
REQ-027 Scenario, clamp and display: RADIX=10, load 8'hAF -> oCOUNT=8'h99; next cycle oSEG shows 9 on both digits.
REQ-028 Scenario, leading-zero blanking: with BLANK_LEADING_ZERO_EN defined and count 8'h05 -> upper digit oSEG=7'b1111111; without the macro -> upper digit shows 7'b1000000.

Source files
------------

// File: rtl/multi_digit_counter.sv
// multi_digit_counter
//   Multi-digit up/down counter (BCD or hex digits) advanced by a clock-divided
//   tick, with a one-hot LED walker and registered active-low 7-segment outputs.
//
//   Parameters: CLK_HZ / TICK_HZ set the tick divider DIV (must be >= 2),
//   DIGITS (1..8) 4-bit digits of radix RADIX (10 or 16), LED_W walker width.
//
//   Ports:
//     CLOCK_50   in   clock
//     RESET_N    in   synchronous active-low reset
//     iRUN       in   1 = count, 0 = pause (prescaler and count hold)
//     iDIR       in   1 = up, 0 = down
//     iCLR       in   synchronous clear (count 0, walker 1)
//     iLOAD      in   load strobe for iLOAD_VAL (digit 0 in [3:0])
//     oCOUNT     out  current count
//     oSEG       out  active-low segments, digit d in [7d+6:7d], bit 0 = a
//     oLED       out  one-hot walker, rotates left on up ticks, right on down
//     oTICK      out  one-cycle pulse when the count advances
//     oWRAP      out  one-cycle pulse coincident with a wrapping tick
//
//   Build option: define BLANK_LEADING_ZERO_EN to blank zero digits above the
//   most significant nonzero digit (digit 0 always displays).
module multi_digit_counter #(
   parameter int unsigned CLK_HZ  = 50000000,
   parameter int unsigned TICK_HZ = 1,
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned RADIX   = 16,
   parameter int unsigned LED_W   = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   input  logic                  iRUN,
   input  logic                  iDIR,
   input  logic                  iCLR,
   input  logic                  iLOAD,
   input  logic [4*DIGITS-1:0]   iLOAD_VAL,
   output logic [4*DIGITS-1:0]   oCOUNT,
   output logic [7*DIGITS-1:0]   oSEG,
   output logic [LED_W-1:0]      oLED,
   output logic                  oTICK,
   output logic                  oWRAP
);

   localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
   localparam int unsigned PW       = $clog2(DIV);
   localparam logic [PW-1:0] PresMax  = PW'(DIV - 1);
   localparam logic [3:0]    DigitMax = 4'(RADIX - 1);
   localparam logic [6:0]    SegZero  = 7'b1000000;
   localparam logic [6:0]    SegBlank = 7'b1111111;
   localparam logic [LED_W-1:0] LedInit = {{(LED_W-1){1'b0}}, 1'b1};

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         4'hF: g = 7'h0E;
         default: g = SegBlank;
      endcase
      return g;
   endfunction

   logic [PW-1:0]         presc_q, presc_d;
   logic [4*DIGITS-1:0]   count_q, count_d;
   logic [LED_W-1:0]      led_q, led_d;
   logic                  tick_q, tick_d;
   logic                  wrap_q, wrap_d;
   logic [7*DIGITS-1:0]   seg_q, seg_d;

   logic                  tick_now;
   logic                  carry;
   logic [4*DIGITS-1:0]   count_step;
   logic [4*DIGITS-1:0]   load_clamped;
   logic [LED_W-1:0]      led_rot;

   // Ripple carry/borrow across digits; carry out of the top digit is a wrap.
   always_comb begin
      logic [3:0] dig;
      carry      = 1'b1;
      count_step = count_q;
      for (int d = 0; d < int'(DIGITS); d++) begin
         dig = count_q[4*d +: 4];
         if (carry) begin
            if (iDIR) begin
               if (dig >= DigitMax) begin
                  count_step[4*d +: 4] = 4'd0;
               end else begin
                  count_step[4*d +: 4] = dig + 4'd1;
                  carry                = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  count_step[4*d +: 4] = DigitMax;
               end else begin
                  count_step[4*d +: 4] = dig - 4'd1;
                  carry                = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      logic [3:0] lv;
      load_clamped = iLOAD_VAL;
      for (int d = 0; d < int'(DIGITS); d++) begin
         lv = iLOAD_VAL[4*d +: 4];
         if (RADIX == 10 && lv > 4'd9) begin
            load_clamped[4*d +: 4] = 4'd9;
         end
      end
   end

   assign tick_now = iRUN && (presc_q == PresMax);
   assign led_rot  = iDIR ? {led_q[LED_W-2:0], led_q[LED_W-1]}
                          : {led_q[0], led_q[LED_W-1:1]};

   // Clear beats load beats tick; a tick that loses is simply dropped.
   always_comb begin
      presc_d = presc_q;
      count_d = count_q;
      led_d   = led_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (iCLR) begin
         presc_d = '0;
         count_d = '0;
         led_d   = LedInit;
      end else if (iLOAD) begin
         presc_d = '0;
         count_d = load_clamped;
      end else if (iRUN) begin
         if (tick_now) begin
            presc_d = '0;
            count_d = count_step;
            led_d   = led_rot;
            tick_d  = 1'b1;
            wrap_d  = carry;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Segments follow the registered count, hence one cycle behind oCOUNT.
   always_comb begin
      logic [3:0] dig;
      logic       nonzero_above;
      nonzero_above = 1'b0;
      seg_d         = '0;
      for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
         dig = count_q[4*d +: 4];
`ifdef BLANK_LEADING_ZERO_EN
         if (d != 0 && !nonzero_above && dig == 4'd0) begin
            seg_d[7*d +: 7] = SegBlank;
         end else begin
            seg_d[7*d +: 7] = hex_glyph(dig);
         end
`else
         seg_d[7*d +: 7] = hex_glyph(dig);
`endif
         nonzero_above = nonzero_above | (dig != 4'd0);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         presc_q <= '0;
         count_q <= '0;
         led_q   <= LedInit;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         seg_q   <= {DIGITS{SegZero}};
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
         led_q   <= led_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
         seg_q   <= seg_d;
      end
   end

   assign oCOUNT = count_q;
   assign oSEG   = seg_q;
   assign oLED   = led_q;
   assign oTICK  = tick_q;
   assign oWRAP  = wrap_q;

endmodule

// File: tb/tb_multi_digit_counter.sv
// tb_multi_digit_counter
//   Bench for multi_digit_counter with DIV=10, DIGITS=2, LED_W=8. Two instances
//   share all inputs: u_hex (RADIX=16) and u_dec (RADIX=10).
module tb_multi_digit_counter;

   localparam int unsigned DIV = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run, dir, clr, load;
   logic [7:0]  load_val;

   logic [7:0]  hx_count, dc_count;
   logic [13:0] hx_seg, dc_seg;
   logic [7:0]  hx_led, dc_led;
   logic        hx_tick, dc_tick, hx_wrap, dc_wrap;

   always #5 clk = ~clk;

   multi_digit_counter #(
      .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .RADIX(16), .LED_W(8)
   ) u_hex (
      .CLOCK_50(clk), .RESET_N(rst_n), .iRUN(run), .iDIR(dir), .iCLR(clr),
      .iLOAD(load), .iLOAD_VAL(load_val), .oCOUNT(hx_count), .oSEG(hx_seg),
      .oLED(hx_led), .oTICK(hx_tick), .oWRAP(hx_wrap)
   );

   multi_digit_counter #(
      .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .RADIX(10), .LED_W(8)
   ) u_dec (
      .CLOCK_50(clk), .RESET_N(rst_n), .iRUN(run), .iDIR(dir), .iCLR(clr),
      .iLOAD(load), .iLOAD_VAL(load_val), .oCOUNT(dc_count), .oSEG(dc_seg),
      .oLED(dc_led), .oTICK(dc_tick), .oWRAP(dc_wrap)
   );

   typedef struct packed {
      logic [7:0] count;
      logic [7:0] led;
      logic       wrap;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

`ifdef BLANK_LEADING_ZERO_EN
   localparam logic [6:0] UpperZero = 7'b1111111;
`else
   localparam logic [6:0] UpperZero = 7'b1000000;
`endif

   // Count value as an integer in the given radix, stepped modulo radix^2.
   function automatic logic [7:0] model_next(input logic [7:0] v, input bit up,
                                             input int radix, output bit wrap);
      int n;
      int top;
      n    = int'(v[7:4]) * radix + int'(v[3:0]);
      top  = radix * radix;
      wrap = up ? (n == top - 1) : (n == 0);
      n    = up ? (n + 1) % top : (n + top - 1) % top;
      return {4'(n / radix), 4'(n % radix)};
   endfunction

   function automatic logic [7:0] model_led(input logic [7:0] l, input bit up);
      return up ? (l << 1) | (l >> 7) : (l >> 1) | (l << 7);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] v);
      load     = 1'b1;
      load_val = v;
      step();
      load     = 1'b0;
   endtask

   task automatic wait_dc_tick(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 2 * int'(DIV); i++) begin
         step();
         if (dc_tick) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      run = 1'b1; dir = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
      apply_reset();
      n_checks++;
      if (hx_count !== 8'h00 || dc_count !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_count: got %h/%h want 00", hx_count, dc_count);
      end
      n_checks++;
      if (hx_led !== 8'h01 || dc_led !== 8'h01) begin
         n_errors++;
         $display("FAIL reset_led: got %h/%h want 01", hx_led, dc_led);
      end
      n_checks++;
      if (hx_tick !== 1'b0 || hx_wrap !== 1'b0 || dc_tick !== 1'b0 || dc_wrap !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_pulses: got tick %b wrap %b want 0 0", hx_tick, hx_wrap);
      end
      n_checks++;
      if (hx_seg !== {7'h40, 7'h40} || dc_seg !== {7'h40, 7'h40}) begin
         n_errors++;
         $display("FAIL reset_seg: got %h/%h want %h", hx_seg, dc_seg, {7'h40, 7'h40});
      end
   endtask

   task automatic test_up_count();
      exp_t e;
      run = 1'b1; dir = 1'b1;
      apply_reset();
      sb_q.push_back('{count: 8'h01, led: 8'h02, wrap: 1'b0});
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i < 10) begin
            n_checks++;
            if (hx_tick !== 1'b0) begin
               n_errors++;
               $display("FAIL up_early_tick: cycle %0d got %b want 0", i, hx_tick);
            end
         end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (hx_tick !== 1'b1 || hx_count !== e.count || hx_led !== e.led
                || hx_wrap !== e.wrap) begin
               n_errors++;
               $display("FAIL up_tick: got tick %b cnt %h led %h wrap %b want 1 %h %h %b",
                        hx_tick, hx_count, hx_led, hx_wrap, e.count, e.led, e.wrap);
            end
         end
      end
      step();
      n_checks++;
      if (hx_tick !== 1'b0) begin
         n_errors++;
         $display("FAIL up_tick_width: got %b want 0", hx_tick);
      end
   endtask

   task automatic test_up_wrap();
      exp_t e;
      bit   w;
      bit   seen;
      run = 1'b0; dir = 1'b1;
      do_clear();
      do_load(8'h99);
      n_checks++;
      if (dc_count !== 8'h99 || dc_led !== 8'h01) begin
         n_errors++;
         $display("FAIL wrap_load: got cnt %h led %h want 99 01", dc_count, dc_led);
      end
      e.count = model_next(8'h99, 1'b1, 10, w);
      e.led   = model_led(8'h01, 1'b1);
      e.wrap  = w;
      sb_q.push_back(e);
      run = 1'b1;
      wait_dc_tick(seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen || dc_count !== e.count || dc_led !== e.led || dc_wrap !== e.wrap) begin
         n_errors++;
         $display("FAIL up_wrap: seen %b got cnt %h led %h wrap %b want %h %h %b",
                  seen, dc_count, dc_led, dc_wrap, e.count, e.led, e.wrap);
      end
   endtask

   task automatic test_down_borrow();
      exp_t       e;
      bit         w;
      bit         seen;
      logic [7:0] m_val;
      logic [7:0] m_led;
      run = 1'b0; dir = 1'b0;
      do_clear();
      do_load(8'h10);
      m_val = 8'h10;
      m_led = 8'h01;
      for (int k = 0; k < 11; k++) begin
         m_val   = model_next(m_val, 1'b0, 10, w);
         m_led   = model_led(m_led, 1'b0);
         e.count = m_val;
         e.led   = m_led;
         e.wrap  = w;
         sb_q.push_back(e);
      end
      run = 1'b1;
      for (int k = 0; k < 11; k++) begin
         wait_dc_tick(seen);
         n_checks++;
         if (!seen) begin
            n_errors++;
            $display("FAIL down_timeout: tick %0d got none want tick", k);
            sb_q.delete();
            break;
         end
         e = sb_q.pop_front();
         n_checks++;
         if (dc_count !== e.count || dc_led !== e.led || dc_wrap !== e.wrap) begin
            n_errors++;
            $display("FAIL down_tick%0d: got cnt %h led %h wrap %b want %h %h %b",
                     k, dc_count, dc_led, dc_wrap, e.count, e.led, e.wrap);
         end
         step();
         n_checks++;
         if (dc_tick !== 1'b0 || dc_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL down_pulse_width: got tick %b wrap %b want 0 0", dc_tick, dc_wrap);
         end
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL down_sb_left: got %0d want 0", sb_q.size());
      end
   endtask

   task automatic test_pause_collision();
      bit any_tick;
      run = 1'b0; dir = 1'b1;
      do_clear();
      run = 1'b1;
      repeat (4) step();
      run = 1'b0;
      any_tick = 1'b0;
      repeat (25) begin
         step();
         any_tick = any_tick | hx_tick;
      end
      n_checks++;
      if (any_tick !== 1'b0 || hx_count !== 8'h00) begin
         n_errors++;
         $display("FAIL pause_hold: got tick %b cnt %h want 0 00", any_tick, hx_count);
      end
      run = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         n_checks++;
         if (hx_tick !== (i == 6)) begin
            n_errors++;
            $display("FAIL pause_resume: cycle %0d got tick %b want %b", i, hx_tick, i == 6);
         end
      end
      n_checks++;
      if (hx_count !== 8'h01 || hx_led !== 8'h02) begin
         n_errors++;
         $display("FAIL resume_count: got cnt %h led %h want 01 02", hx_count, hx_led);
      end
      repeat (9) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_checks++;
      if (hx_count !== 8'h00 || hx_led !== 8'h01 || hx_tick !== 1'b0 || hx_wrap !== 1'b0) begin
         n_errors++;
         $display("FAIL clr_collision: got cnt %h led %h tick %b wrap %b want 00 01 0 0",
                  hx_count, hx_led, hx_tick, hx_wrap);
      end
      repeat (9) step();
      do_load(8'h37);
      n_checks++;
      if (hx_count !== 8'h37 || hx_led !== 8'h01 || hx_tick !== 1'b0) begin
         n_errors++;
         $display("FAIL load_collision: got cnt %h led %h tick %b want 37 01 0",
                  hx_count, hx_led, hx_tick);
      end
      step();
      n_checks++;
      if (hx_tick !== 1'b0 || hx_count !== 8'h37) begin
         n_errors++;
         $display("FAIL load_no_late_tick: got tick %b cnt %h want 0 37", hx_tick, hx_count);
      end
   endtask

   task automatic test_reset_midcount();
      run = 1'b1; dir = 1'b1;
      do_load(8'h55);
      repeat (7) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_checks++;
      if (hx_count !== 8'h00 || hx_led !== 8'h01) begin
         n_errors++;
         $display("FAIL midreset_state: got cnt %h led %h want 00 01", hx_count, hx_led);
      end
      for (int i = 1; i <= 10; i++) begin
         step();
         n_checks++;
         if (hx_tick !== (i == 10)) begin
            n_errors++;
            $display("FAIL midreset_period: cycle %0d got tick %b want %b", i, hx_tick, i == 10);
         end
      end
      n_checks++;
      if (hx_count !== 8'h01) begin
         n_errors++;
         $display("FAIL midreset_count: got %h want 01", hx_count);
      end
   endtask

   task automatic test_clamp_display();
      run = 1'b0;
      do_load(8'hAF);
      n_checks++;
      if (dc_count !== 8'h99 || hx_count !== 8'hAF) begin
         n_errors++;
         $display("FAIL clamp: got dec %h hex %h want 99 af", dc_count, hx_count);
      end
      step();
      n_checks++;
      if (dc_seg !== {7'h10, 7'h10}) begin
         n_errors++;
         $display("FAIL seg_dec99: got %h want %h", dc_seg, {7'h10, 7'h10});
      end
      n_checks++;
      if (hx_seg !== {7'h08, 7'h0E}) begin
         n_errors++;
         $display("FAIL seg_hexAF: got %h want %h", hx_seg, {7'h08, 7'h0E});
      end
   endtask

   task automatic test_blank();
      run = 1'b0;
      do_load(8'h05);
      step();
      n_checks++;
      if (hx_seg !== {UpperZero, 7'h12} || dc_seg !== {UpperZero, 7'h12}) begin
         n_errors++;
         $display("FAIL blank_05: got %h/%h want %h", hx_seg, dc_seg, {UpperZero, 7'h12});
      end
      do_load(8'h00);
      step();
      n_checks++;
      if (hx_seg !== {UpperZero, 7'h40}) begin
         n_errors++;
         $display("FAIL blank_00: got %h want %h", hx_seg, {UpperZero, 7'h40});
      end
      do_load(8'h50);
      step();
      n_checks++;
      if (hx_seg !== {7'h12, 7'h40}) begin
         n_errors++;
         $display("FAIL blank_50: got %h want %h", hx_seg, {7'h12, 7'h40});
      end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_up_wrap();
      test_down_borrow();
      test_pause_collision();
      test_reset_midcount();
      test_clamp_display();
      test_blank();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
